input_conditioner: RTL and testbench

- Upstream front end of the stopwatch datapath.
- Synchronises and debounces the raw board switches and pause pushbutton.
- Produces the clean `sel`, `adj` and `pause` control levels consumed by the clock divider and the counter.
- Runs on the board system clock and sits between the FPGA pins and the stopwatch core.

---
 rtl/input_conditioner_if.sv | 22 ++
 rtl/input_conditioner.sv | 123 ++++++++++++
 tb/tb_input_conditioner.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/input_conditioner_if.sv
// Raw pin inputs and conditioned control levels of the stopwatch input conditioner.
// The master side drives the pins; the slave side is the conditioner itself.
interface input_conditioner_if;
  logic sw_sel_raw;
  logic sw_adj_raw;
  logic btn_pause_raw;
  logic sel;
  logic adj;
  logic pause;
  logic pause_pulse;
  logic clr_req;

  modport master (
    output sw_sel_raw, sw_adj_raw, btn_pause_raw,
    input  sel, adj, pause, pause_pulse, clr_req
  );

  modport slave (
    input  sw_sel_raw, sw_adj_raw, btn_pause_raw,
    output sel, adj, pause, pause_pulse, clr_req
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronises and debounces the stopwatch switches and pause button.
// Optional long-press clear strobe: define LONG_PRESS_CLEAR_EN.
module input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned HOLD_CYCLES     = 100000000,
  parameter int unsigned HOLD_W          = 27
) (
  input  logic               clk,
  input  logic               rst,
  input_conditioner_if.slave io
);

  localparam int unsigned N_CH   = 3;
  localparam int unsigned CH_SEL = 0;
  localparam int unsigned CH_ADJ = 1;
  localparam int unsigned CH_BTN = 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb_min
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_chk_cnt_w
    $error("CNT_W too small for DEBOUNCE_CYCLES");
  end
  if ((64'(1) << HOLD_W) <= 64'(HOLD_CYCLES)) begin : g_chk_hold_w
    $error("HOLD_W too small for HOLD_CYCLES");
  end

  logic [N_CH-1:0]  raw;
  logic [N_CH-1:0]  s1;
  logic [N_CH-1:0]  s2;
  logic [N_CH-1:0]  st;
  logic [CNT_W-1:0] cnt [N_CH];
  logic             st_btn_d;
  logic             press;
  logic             clr_fire;
  logic             clr_q;
  logic             pause_q;
  logic             pulse_q;

  assign raw[CH_SEL] = io.sw_sel_raw;
  assign raw[CH_ADJ] = io.sw_adj_raw;
  assign raw[CH_BTN] = io.btn_pause_raw;

  // Two-flop synchroniser plus per-channel debounce; stable value moves only after a full run.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      st <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < N_CH; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          st[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = st[CH_BTN] & ~st_btn_d;

`ifdef LONG_PRESS_CLEAR_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Fires on the edge the hold count first reaches HOLD_CYCLES; saturation prevents re-fire.
  assign clr_fire = st[CH_BTN] & ~press & (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      clr_q    <= 1'b0;
    end else begin
      if (!st[CH_BTN] || press) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      clr_q <= clr_fire;
    end
  end
`else
  assign clr_fire = 1'b0;
  assign clr_q    = 1'b0;
`endif

  // Press edge toggles pause; a long-press clear overrides it back to running.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_btn_d <= 1'b0;
      pause_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      st_btn_d <= st[CH_BTN];
      pulse_q  <= press;
      if (clr_fire) begin
        pause_q <= 1'b0;
      end else if (press) begin
        pause_q <= ~pause_q;
      end
    end
  end

  assign io.sel         = st[CH_SEL];
  assign io.adj         = st[CH_ADJ];
  assign io.pause       = pause_q;
  assign io.pause_pulse = pulse_q;
  assign io.clr_req     = clr_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner: stimulus queues the expected output changes
// (cycle + value); a negedge monitor pops and compares whenever the outputs change.
module tb_input_conditioner;

  localparam int END_CYC = 190;

  typedef struct packed {
    logic [31:0] cyc;
    logic [4:0]  vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  logic rst_q = 1'b0;
  bit   fin = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  exp_t sb[$];
  exp_t e;
  logic [4:0] cur;
  logic [4:0] last = 5'b0;

  input_conditioner_if ifc ();

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3),
    .HOLD_CYCLES    (20),
    .HOLD_W         (5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (ifc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor: {sel, adj, pause, pause_pulse, clr_req}
  always @(negedge clk) begin
    cur = {ifc.sel, ifc.adj, ifc.pause, ifc.pause_pulse, ifc.clr_req};
    if (rst_q) begin
      n_vec++;
      if (cur !== 5'b0) begin
        n_miss++;
        $display("FAIL reset_outputs cyc=%0d got=%b want=00000", cyc, cur);
      end
      last = cur;
    end else if (cur !== last) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_change cyc=%0d got=%b (no change expected)", cyc, cur);
      end else begin
        e = sb.pop_front();
        if (e.cyc != 32'(cyc) || e.vec !== cur) begin
          n_miss++;
          $display("FAIL output_change cyc=%0d got=%b want cyc=%0d val=%b", cyc, cur, e.cyc, e.vec);
        end
      end
      last = cur;
    end
    if (cyc == END_CYC && !fin) begin
      n_vec++;
      if (sb.size() != 0) begin
        n_miss++;
        e = sb[0];
        $display("FAIL pending_changes left=%0d got none, next want cyc=%0d val=%b", sb.size(), e.cyc, e.vec);
      end
      fin = 1'b1;
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int c, input logic [4:0] v);
    sb.push_back('{cyc: 32'(c), vec: v});
  endtask

  initial begin
    // Reset with all inputs high: switches and held button resolve after reset release
    rst = 1'b1;
    ifc.sw_sel_raw    = 1'b1;
    ifc.sw_adj_raw    = 1'b1;
    ifc.btn_pause_raw = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    expect_at(9,  5'b11000);
    expect_at(10, 5'b11110);
    expect_at(11, 5'b11100);

    // Release everything: no toggle on button release
    wait_cyc(14);
    ifc.sw_sel_raw    = 1'b0;
    ifc.sw_adj_raw    = 1'b0;
    ifc.btn_pause_raw = 1'b0;
    expect_at(20, 5'b00100);

    // Clean press held 10 cycles
    wait_cyc(26);
    ifc.btn_pause_raw = 1'b1;
    expect_at(33, 5'b00010);
    expect_at(34, 5'b00000);
    wait_cyc(36);
    ifc.btn_pause_raw = 1'b0;

    // Bouncy press: 2-cycle pulses then stable high
    wait_cyc(50); ifc.btn_pause_raw = 1'b1;
    wait_cyc(52); ifc.btn_pause_raw = 1'b0;
    wait_cyc(54); ifc.btn_pause_raw = 1'b1;
    wait_cyc(56); ifc.btn_pause_raw = 1'b0;
    wait_cyc(58); ifc.btn_pause_raw = 1'b1;
    expect_at(65, 5'b00110);
    expect_at(66, 5'b00100);
    wait_cyc(70); ifc.btn_pause_raw = 1'b0;

    // 3-cycle select glitch is rejected
    wait_cyc(80); ifc.sw_sel_raw = 1'b1;
    wait_cyc(83); ifc.sw_sel_raw = 1'b0;

    // 4-cycle select pulse is exactly long enough to pass
    wait_cyc(90); ifc.sw_sel_raw = 1'b1;
    expect_at(96, 5'b10100);
    wait_cyc(94); ifc.sw_sel_raw = 1'b0;
    expect_at(100, 5'b00100);

    // Reset in the middle of an adjust debounce discards the partial count
    wait_cyc(110); ifc.sw_adj_raw = 1'b1;
    wait_cyc(113); rst = 1'b1;
    wait_cyc(114); rst = 1'b0;
    expect_at(120, 5'b01000);

    // Select and button together; long hold
    wait_cyc(130);
    ifc.sw_sel_raw    = 1'b1;
    ifc.btn_pause_raw = 1'b1;
    expect_at(136, 5'b11000);
    expect_at(137, 5'b11110);
    expect_at(138, 5'b11100);
`ifdef LONG_PRESS_CLEAR_EN
    expect_at(157, 5'b11001);
    expect_at(158, 5'b11000);
`endif
    wait_cyc(170);
    ifc.btn_pause_raw = 1'b0;

    wait_cyc(END_CYC + 2);
    if (!fin) begin
      n_vec++;
      n_miss++;
      $display("FAIL monitor_final got=not_done want=done");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
